i2t_guard_multi: RTL and testbench
==================================

Name: i2t_guard_multi

Overview:
Multi-channel I2t over-current protection for the motor/kicker drive channels. Each channel integrates its own over_current flag in a leaky accumulator and removes the drive-enable (act) when the accumulated stress crosses a trip level. It re-enables the channel after the accumulator drains and a programmable cool-down has elapsed. The block sits between the per-channel current comparators and the PWM/gate-drive enable logic.

Parameters:
N_CH, 4, number of independent channels
ACC_W, 32, accumulator width in bits
INC, 4, amount added per clk while over_current is high
DEC, 2, amount subtracted per clk while over_current is low; also the accumulator floor value
TRIP_LVL, 100000000, trip fires when acc > TRIP_LVL with over_current high; acc then clamps to TRIP_LVL
WARN_LVL, 50000000, warn asserted while acc >= WARN_LVL in RUN
RELEASE_LVL, 3, trip ends when acc <= RELEASE_LVL with over_current low
COOL_CYC, 1000, extra hold-off cycles after release before act returns; 0 means no hold-off
CNT_W, 8, width of the per-channel saturating trip counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
over_current  in  N_CH  per-channel over-current flag, synchronous to clk
clr_fault  in  1  single-cycle pulse; clears latched trips (see Optional Feature) and all trip counters
act  out  N_CH  1 = channel drive enabled
warn  out  N_CH  1 = accumulator at or above WARN_LVL in RUN
trip_any  out  1  OR of all channels that are not in RUN
trip_pulse  out  N_CH  one-clk pulse on each RUN->TRIP entry
trip_cnt  out  N_CH*CNT_W  per-channel count of trips, saturating; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset values: acc=DEC, state=RUN, act=all 1, warn=0, trip_any=0, trip_pulse=0, trip_cnt=0, cool counter=0. A reset mid-trip returns to these values immediately.
- All outputs are registered. Decisions use the registered acc value, so they lag the input by one clk.
- Per-channel arithmetic:
  - Add: acc+INC, saturating at 2^ACC_W-1.
  - Subtract: acc-DEC, floored at DEC.
  - Elaboration check: TRIP_LVL+INC < 2^ACC_W, and RELEASE_LVL < WARN_LVL <= TRIP_LVL.
- State RUN (act=1):
  - over_current=1 and acc > TRIP_LVL: go to TRIP; acc<=TRIP_LVL; act<=0; trip_pulse=1; trip_cnt+1 (saturating).
  - over_current=1 otherwise: acc adds INC.
  - over_current=0: acc subtracts DEC.
- State TRIP (act=0):
  - over_current=1: acc holds at TRIP_LVL.
  - over_current=0 and acc <= RELEASE_LVL: acc<=DEC; go to COOL with cool counter loaded to COOL_CYC. If COOL_CYC=0, go straight to RUN with act<=1.
  - over_current=0 otherwise: acc subtracts DEC.
- State COOL (act=0):
  - Each clk the cool counter decrements and acc follows the RUN arithmetic.
  - Counter reaching 0: go to RUN with act<=1.
  - over_current=1 with acc > TRIP_LVL: go back to TRIP, with no trip_pulse and no count.
- warn is driven only in RUN; it is 0 in TRIP and COOL.
- Channels are fully independent. trip_any and the channel outputs update in the same clk.
- clr_fault arriving in the same clk as a trip: the trip still occurs, and trip_cnt ends at 1.

Optional Feature:
I2T_LATCH_EN
- Defined: TRIP becomes sticky. A channel leaves TRIP only when acc <= RELEASE_LVL and clr_fault=1 in the same clk. Otherwise it stays in TRIP with acc draining down to the floor. A clr_fault while acc > RELEASE_LVL is ignored for the state but still clears trip_cnt.
- Undefined: release is automatic, as described above.

Decomposition:
- Package i2t_pkg holds the state enum (RUN, TRIP, COOL), the saturating add/sub functions, and the parameter-check constants.
- Sub-module i2t_channel holds one accumulator, its FSM, cool counter and trip counter. The top level generate-instantiates N_CH of them and builds trip_any.

Test Plan:
All scenarios use N_CH=2, INC=4, DEC=2, TRIP_LVL=20, WARN_LVL=12, RELEASE_LVL=3, COOL_CYC=5.
1. Ch0 over_current held high from reset: acc 2,6,10,14,18,22; act[0] falls on the 6th edge; trip_pulse[0] lasts one clk; warn[0] high from acc=14 until the trip; trip_cnt[0]=1.
2. After scenario 1, drop over_current: acc drains 20->2 in 9 clks; COOL lasts 5 clks; act[0]=1 at the 15th edge after the drop.
3. Alternate 1 clk high / 1 clk low: net +2 per 2 clks; no trip before acc exceeds 20; first trip near cycle 20.
4. Trip ch0 only: act[1] stays 1; trip_any=1 until ch0 returns to RUN.
5. Reassert over_current during COOL for 6 clks: re-trip; trip_cnt unchanged.
6. With I2T_LATCH_EN: drained channel stays at act=0 until clr_fault; act=1 the next clk. Async reset mid-TRIP gives act=all 1 and trip_cnt=0.

Source files
------------

// File: rtl/i2t_pkg.sv
// i2t_pkg: state encoding, saturating accumulator arithmetic and level sanity check for i2t_guard_multi.
package i2t_pkg;
    typedef enum logic [1:0] {RUN, TRIP, COOL} i2t_state_t;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] max_v);
        return (a > max_v - b) ? max_v : a + b;
    endfunction

    function automatic logic [63:0] floor_sub(input logic [63:0] a, input logic [63:0] b, input logic [63:0] floor_v);
        return (a < floor_v + b) ? floor_v : a - b;
    endfunction

    function automatic logic params_ok(input int acc_w, input int inc, input int trip, input int warn, input int rel);
        return (64'(trip) + 64'(inc) < (64'd1 << acc_w)) && (rel < warn) && (warn <= trip);
    endfunction
endpackage

// File: rtl/i2t_channel.sv
// i2t_channel: one leaky I2t accumulator with RUN/TRIP/COOL FSM, cool-down counter and saturating trip counter.
// Define I2T_LATCH_EN to make TRIP sticky until clr_fault arrives with the accumulator drained.
module i2t_channel
    import i2t_pkg::*;
#(
    parameter int ACC_W       = 32,
    parameter int INC         = 4,
    parameter int DEC         = 2,
    parameter int TRIP_LVL    = 100000000,
    parameter int WARN_LVL    = 50000000,
    parameter int RELEASE_LVL = 3,
    parameter int COOL_CYC    = 1000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_oc,
    input  logic             i_clr,
    output logic             o_act,
    output logic             o_warn,
    output logic             o_pulse,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_run_nxt
);
    localparam int               CW     = (COOL_CYC > 0) ? $clog2(COOL_CYC + 1) : 1;
    localparam logic [63:0]      MAX_V  = (64'd1 << ACC_W) - 64'd1;
    localparam logic [ACC_W-1:0] TRIP_V = ACC_W'(TRIP_LVL);
    localparam logic [ACC_W-1:0] WARN_V = ACC_W'(WARN_LVL);
    localparam logic [ACC_W-1:0] REL_V  = ACC_W'(RELEASE_LVL);
    localparam logic [ACC_W-1:0] DEC_V  = ACC_W'(DEC);
    localparam logic [CW-1:0]    COOL_V = CW'(COOL_CYC);

    i2t_state_t       r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt, w_add, w_sub;
    logic [CW-1:0]    r_cool, w_cool_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_act, r_warn, r_pulse;
    logic             w_over, w_rel, w_trip;

    assign w_add  = ACC_W'(sat_add(64'(r_acc), 64'(INC), MAX_V));
    assign w_sub  = ACC_W'(floor_sub(64'(r_acc), 64'(DEC), 64'(DEC)));
    assign w_over = i_oc && (r_acc > TRIP_V);
`ifdef I2T_LATCH_EN
    assign w_rel  = !i_oc && i_clr && (r_acc <= REL_V);
`else
    assign w_rel  = !i_oc && (r_acc <= REL_V);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = i_oc ? w_add : w_sub;
        w_cool_nxt  = r_cool;
        w_trip      = 1'b0;
        case (r_state)
            RUN: if (w_over) begin
                w_state_nxt = TRIP;
                w_acc_nxt   = TRIP_V;
                w_trip      = 1'b1;
            end
            TRIP: if (i_oc) begin
                w_acc_nxt = TRIP_V;
            end else if (w_rel) begin
                w_acc_nxt   = DEC_V;
                w_state_nxt = (COOL_CYC == 0) ? RUN : COOL;
                w_cool_nxt  = COOL_V;
            end
            COOL: begin
                w_cool_nxt = r_cool - CW'(1);
                if (w_over) begin
                    w_state_nxt = TRIP;
                    w_acc_nxt   = TRIP_V;
                end else if (r_cool == CW'(1)) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // a trip coinciding with clr_fault still counts, so the count restarts at 1
    assign w_cnt_nxt = w_trip ? (i_clr ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_W'(1)))
                              : (i_clr ? '0 : r_cnt);
    assign o_run_nxt = (w_state_nxt == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_acc   <= DEC_V;
            r_cool  <= '0;
            r_cnt   <= '0;
            r_act   <= 1'b1;
            r_warn  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cool  <= w_cool_nxt;
            r_cnt   <= w_cnt_nxt;
            r_act   <= o_run_nxt;
            r_warn  <= o_run_nxt && (w_acc_nxt >= WARN_V);
            r_pulse <= w_trip;
        end
    end

    assign o_act   = r_act;
    assign o_warn  = r_warn;
    assign o_pulse = r_pulse;
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/i2t_guard_multi.sv
// i2t_guard_multi: N_CH independent I2t over-current guards gating the drive enables, plus a registered trip_any.
// Optional macro I2T_LATCH_EN (see i2t_channel) makes trips sticky until clr_fault.
module i2t_guard_multi
    import i2t_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int ACC_W       = 32,
    parameter int INC         = 4,
    parameter int DEC         = 2,
    parameter int TRIP_LVL    = 100000000,
    parameter int WARN_LVL    = 50000000,
    parameter int RELEASE_LVL = 3,
    parameter int COOL_CYC    = 1000,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       over_current,
    input  logic                  clr_fault,
    output logic [N_CH-1:0]       act,
    output logic [N_CH-1:0]       warn,
    output logic                  trip_any,
    output logic [N_CH-1:0]       trip_pulse,
    output logic [N_CH*CNT_W-1:0] trip_cnt
);
    logic [N_CH-1:0] w_run_nxt;
    logic            r_trip_any;

    if (!params_ok(ACC_W, INC, TRIP_LVL, WARN_LVL, RELEASE_LVL)) begin : g_bad_params
        $error("i2t_guard_multi: inconsistent ACC_W/INC/TRIP_LVL/WARN_LVL/RELEASE_LVL");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        i2t_channel #(
            .ACC_W(ACC_W), .INC(INC), .DEC(DEC), .TRIP_LVL(TRIP_LVL), .WARN_LVL(WARN_LVL),
            .RELEASE_LVL(RELEASE_LVL), .COOL_CYC(COOL_CYC), .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_oc     (over_current[c]),
            .i_clr    (clr_fault),
            .o_act    (act[c]),
            .o_warn   (warn[c]),
            .o_pulse  (trip_pulse[c]),
            .o_cnt    (trip_cnt[c*CNT_W +: CNT_W]),
            .o_run_nxt(w_run_nxt[c])
        );
    end

    // built from next states so it lands in the same clk as the channel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_trip_any <= 1'b0;
        else        r_trip_any <= ~&w_run_nxt;
    end

    assign trip_any = r_trip_any;
endmodule

// File: tb/tb_i2t_guard_multi.sv
// tb_i2t_guard_multi: three DUTs (COOL_CYC 5/8/0, CNT_W 8/2/8) on shared stimulus, checked every cycle against a rule-level model.
module tb_i2t_guard_multi;
    localparam int INC = 4, DEC = 2, TRIP = 20, WARN = 12, REL = 3;
`ifdef I2T_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif
    localparam int ST_RUN = 0, ST_TRIP = 1, ST_COOL = 2;

    typedef struct {
        int     st;
        longint acc;
        int     cool;
        int     cnt;
        bit     pulse;
    } ch_t;

    logic        clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
    logic [1:0]  oc = 2'b00;
    logic [1:0]  act_a, warn_a, pulse_a, act_b, warn_b, pulse_b, act_c, warn_c, pulse_c;
    logic        tany_a, tany_b, tany_c;
    logic [15:0] cnt_a, cnt_c;
    logic [3:0]  cnt_b;
    ch_t         ma[2], mb[2], mc[2];
    int          n_chk = 0, n_err = 0;

    i2t_guard_multi #(.N_CH(2), .ACC_W(32), .INC(INC), .DEC(DEC), .TRIP_LVL(TRIP), .WARN_LVL(WARN),
                      .RELEASE_LVL(REL), .COOL_CYC(5), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .over_current(oc), .clr_fault(clr), .act(act_a), .warn(warn_a),
        .trip_any(tany_a), .trip_pulse(pulse_a), .trip_cnt(cnt_a));
    i2t_guard_multi #(.N_CH(2), .ACC_W(32), .INC(INC), .DEC(DEC), .TRIP_LVL(TRIP), .WARN_LVL(WARN),
                      .RELEASE_LVL(REL), .COOL_CYC(8), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .over_current(oc), .clr_fault(clr), .act(act_b), .warn(warn_b),
        .trip_any(tany_b), .trip_pulse(pulse_b), .trip_cnt(cnt_b));
    i2t_guard_multi #(.N_CH(2), .ACC_W(32), .INC(INC), .DEC(DEC), .TRIP_LVL(TRIP), .WARN_LVL(WARN),
                      .RELEASE_LVL(REL), .COOL_CYC(0), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .over_current(oc), .clr_fault(clr), .act(act_c), .warn(warn_c),
        .trip_any(tany_c), .trip_pulse(pulse_c), .trip_cnt(cnt_c));

    always #5 clk = ~clk;

    function automatic ch_t step(input ch_t m, input logic o, input logic c, input int cool_cyc, input int cnt_max);
        ch_t    n = m;
        longint up = m.acc + INC;
        longint dn = (m.acc - DEC < DEC) ? DEC : m.acc - DEC;
        n.pulse = 1'b0;
        if (m.st == ST_RUN) begin
            if (o && m.acc > TRIP) begin
                n.st = ST_TRIP;
                n.acc = TRIP;
                n.pulse = 1'b1;
                n.cnt = c ? 1 : ((m.cnt < cnt_max) ? m.cnt + 1 : cnt_max);
            end else n.acc = o ? up : dn;
        end else if (m.st == ST_TRIP) begin
            if (o) n.acc = TRIP;
            else if (m.acc <= REL && (!LATCH || c)) begin
                n.acc = DEC;
                n.st = (cool_cyc == 0) ? ST_RUN : ST_COOL;
                n.cool = cool_cyc;
            end else n.acc = dn;
        end else begin
            n.cool = m.cool - 1;
            if (o && m.acc > TRIP) begin
                n.st = ST_TRIP;
                n.acc = TRIP;
            end else begin
                n.acc = o ? up : dn;
                if (n.cool == 0) n.st = ST_RUN;
            end
        end
        if (c && !n.pulse) n.cnt = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ma[i] <= '{ST_RUN, DEC, 0, 0, 1'b0};
                mb[i] <= '{ST_RUN, DEC, 0, 0, 1'b0};
                mc[i] <= '{ST_RUN, DEC, 0, 0, 1'b0};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ma[i] <= step(ma[i], oc[i], clr, 5, 255);
                mb[i] <= step(mb[i], oc[i], clr, 8, 3);
                mc[i] <= step(mc[i], oc[i], clr, 0, 255);
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input ch_t m0, input ch_t m1, input logic [1:0] a, input logic [1:0] w,
                       input logic [1:0] p, input logic t, input logic [15:0] c, input int cw);
        logic [1:0] ea;
        ea = {m1.st == ST_RUN, m0.st == ST_RUN};
        chk({tag, ".act"}, a, ea);
        chk({tag, ".warn"}, w, {ea[1] && m1.acc >= WARN, ea[0] && m0.acc >= WARN});
        chk({tag, ".pulse"}, p, {m1.pulse, m0.pulse});
        chk({tag, ".trip_any"}, t, ea != 2'b11);
        chk({tag, ".cnt"}, c, longint'(m1.cnt) * (64'd1 << cw) + m0.cnt);
    endtask

    always @(negedge clk) begin
        cmp("A", ma[0], ma[1], act_a, warn_a, pulse_a, tany_a, cnt_a, 8);
        cmp("B", mb[0], mb[1], act_b, warn_b, pulse_b, tany_b, {12'd0, cnt_b}, 2);
        cmp("C", mc[0], mc[1], act_c, warn_c, pulse_c, tany_c, cnt_c, 8);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        oc = 2'b01;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.act", act_a, 2'b11);
        chk("rst.warn", warn_a, 2'b00);
        chk("rst.trip_any", tany_a, 1'b0);
        chk("rst.pulse", pulse_a, 2'b00);
        chk("rst.cnt", cnt_a, 16'd0);
        chk("rst.model_acc", ma[0].acc, 2);
        @(negedge clk) rst_n = 1'b1;
        edges(5);
        chk("s1.model_acc", ma[0].acc, 22);
        chk("s1.act_pre", act_a[0], 1'b1);
        chk("s1.warn_pre", warn_a[0], 1'b1);
        edges(1);
        chk("s1.act_trip", act_a, 2'b10);
        chk("s1.pulse", pulse_a, 2'b01);
        chk("s4.trip_any", tany_a, 1'b1);
        chk("s1.cnt", cnt_a[7:0], 8'd1);
        chk("s1.warn_trip", warn_a[0], 1'b0);
        edges(1);
        chk("s1.pulse_end", pulse_a[0], 1'b0);
        chk("s1.model_hold", ma[0].acc, 20);
        oc = 2'b00;
`ifdef I2T_LATCH_EN
        edges(12);
        chk("s6.latched_c", act_c[0], 1'b0);
        chk("s6.latched_a", act_a[0], 1'b0);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        chk("s6.release_c", act_c, 2'b11);
        chk("s6.cnt_clr", cnt_c, 16'd0);
        chk("s6.cool_a", act_a[0], 1'b0);
        edges(5);
        chk("s6.run_a", act_a, 2'b11);
`else
        edges(9);
        chk("s2.model_drain", ma[0].acc, 2);
        chk("s2.still_trip", act_a[0], 1'b0);
        edges(1);
        chk("s2.c_no_cool", act_c[0], 1'b1);
        chk("s2.a_cool", act_a[0], 1'b0);
        edges(4);
        chk("s2.a_cool_end", act_a[0], 1'b0);
        chk("s4.trip_any_cool", tany_a, 1'b1);
        edges(1);
        chk("s2.a_run", act_a[0], 1'b1);
        chk("s4.trip_any_clear", tany_a, 1'b0);
        edges(2);
        chk("s2.b_cool_end", act_b[0], 1'b0);
        edges(1);
        chk("s2.b_run", act_b[0], 1'b1);
        k = 0;
        for (int e = 1; e <= 40 && k == 0; e++) begin
            oc[1] = (e % 2 == 1);
            edges(1);
            if (pulse_a[1]) k = e;
        end
        chk("s3.first_trip_edge", k, 21);
        oc[1] = 1'b0;
        edges(25);
        oc[0] = 1'b1;
        edges(6);
        oc[0] = 1'b0;
        edges(10);
        chk("s5.b_in_cool", mb[0].st, ST_COOL);
        chk("s5.b_cnt_before", cnt_b[1:0], 2'd2);
        oc[0] = 1'b1;
        edges(6);
        chk("s5.b_retrip_act", act_b[0], 1'b0);
        chk("s5.b_retrip_pulse", pulse_b[0], 1'b0);
        chk("s5.b_cnt_after", cnt_b[1:0], 2'd2);
        chk("s5.b_model_st", mb[0].st, ST_TRIP);
        oc[0] = 1'b0;
        edges(30);
        oc[0] = 1'b1;
        edges(5);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        chk("clr_trip.pulse", pulse_a[0], 1'b1);
        chk("clr_trip.cnt0", cnt_a[7:0], 8'd1);
        chk("clr_trip.cnt1", cnt_a[15:8], 8'd0);
        oc[0] = 1'b0;
        edges(20);
        for (int r = 0; r < 4; r++) begin
            oc[0] = 1'b1;
            edges(6);
            oc[0] = 1'b0;
            edges(20);
        end
        chk("sat.a_cnt", cnt_a[7:0], 8'd5);
        chk("sat.b_cnt", cnt_b[1:0], 2'd3);
        clr = 1'b1;
        edges(1);
        clr = 1'b0;
        chk("clr.a_cnt", cnt_a, 16'd0);
        chk("clr.b_cnt", cnt_b, 4'd0);
`endif
        oc[0] = 1'b1;
        edges(8);
        chk("s6.pre_reset_act", act_a[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6.reset_act", act_a, 2'b11);
        chk("s6.reset_cnt", cnt_a, 16'd0);
        chk("s6.reset_trip_any", tany_a, 1'b0);
        @(negedge clk);
        oc = 2'b00;
        rst_n = 1'b1;
        edges(3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end by %0t", $time);
        $fatal(1);
    end
endmodule
